// File: rtl/rijndael_shift_rows.sv
// rijndael_shift_rows: Rijndael ShiftRows/InvShiftRows with a 1-cycle output register and one-entry skid buffer
module rijndael_shift_rows #(
    parameter int NB = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32*NB-1:0]  in_data,
    input  logic              in_inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_data,
    output logic              out_inv
);
    localparam int W = 32*NB;

    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
        $error("rijndael_shift_rows: NB must be 4, 6 or 8");
    end

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t         r_state;
    logic           r_or_valid;
    logic [W-1:0]   r_or_data;
    logic           r_or_inv;
    logic           r_sk_valid;
    logic [W-1:0]   r_sk_data;
    logic           r_sk_inv;
    logic           r_in_ready;
    logic [W-1:0]   w_shift;
    logic           w_accept;

    // Row offsets: the wide 256-bit block uses a larger spread on rows 2 and 3
    function automatic int row_off(input int r);
        return r == 0 ? 0 : r == 1 ? 1 : r == 2 ? (NB == 8 ? 3 : 2) : (NB == 8 ? 4 : 3);
    endfunction

    assign w_accept  = in_valid && r_in_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = r_or_valid;
    assign out_data  = r_or_data;
    assign out_inv   = r_or_inv;

    // Pure byte routing: each output byte (r,c) picks input byte (r, c +/- offset mod NB)
    always_comb begin
        w_shift = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_shift[W-1-8*(4*c+r) -: 8] =
                    in_data[W-1-8*(4*((in_inv ? c + NB - row_off(r) : c + row_off(r)) % NB) + r) -: 8];
            end
        end
    end

    // Output register plus skid register; in_ready is its own flop tracking an empty skid slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_or_valid <= 1'b0;
            r_or_data  <= '0;
            r_or_inv   <= 1'b0;
            r_sk_valid <= 1'b0;
            r_sk_data  <= '0;
            r_sk_inv   <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state    <= ONE;
                        r_or_valid <= 1'b1;
                        r_or_data  <= w_shift;
                        r_or_inv   <= in_inv;
                    end
                end
                ONE: begin
                    if (w_accept && out_ready) begin
                        r_or_data <= w_shift;
                        r_or_inv  <= in_inv;
                    end else if (w_accept) begin
                        r_state    <= FULL;
                        r_sk_valid <= 1'b1;
                        r_sk_data  <= w_shift;
                        r_sk_inv   <= in_inv;
                        r_in_ready <= 1'b0;
                    end else if (out_ready) begin
                        r_state    <= EMPTY;
                        r_or_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        r_state    <= ONE;
                        r_or_data  <= r_sk_data;
                        r_or_inv   <= r_sk_inv;
                        r_sk_valid <= 1'b0;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= EMPTY;
                    r_or_valid <= 1'b0;
                    r_sk_valid <= 1'b0;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rijndael_shift_rows.sv
// tb_rijndael_shift_rows: scoreboard bench for the ShiftRows pipeline stage
module tb_rijndael_shift_rows;
    localparam int W  = 128;
    localparam int W8 = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, in_inv, out_valid, out_ready, out_inv;
    logic [W-1:0]  in_data, out_data;
    logic          in_valid8, in_ready8, in_inv8, out_valid8, out_ready8, out_inv8;
    logic [W8-1:0] in_data8, out_data8;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    logic [W:0] q[$];
    logic [W:0] exp_item;

    rijndael_shift_rows #(.NB(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_inv(out_inv)
    );

    rijndael_shift_rows #(.NB(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .in_inv(in_inv8), .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .out_inv(out_inv8)
    );

    // Reference model for NB=4: build a 4x4 state matrix, rotate each row r by r
    function automatic logic [W-1:0] ref4(input logic [W-1:0] d, input logic inv);
        logic [7:0] s [4][4];
        logic [W-1:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = d[W-1-8*(4*c+r) -: 8];
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[W-1-8*(4*c+r) -: 8] = s[r][inv ? (c + 4 - r) % 4 : (c + r) % 4];
        return o;
    endfunction

    // Scoreboard: push on accept, pop and compare on output transfer
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (out_valid && out_ready) begin
                checks++;
                n_out++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard unexpected output got=%h", {out_inv, out_data});
                end else begin
                    exp_item = q.pop_front();
                    if ({out_inv, out_data} !== exp_item) begin
                        errors++;
                        $display("FAIL scoreboard order/data got=%h exp=%h", {out_inv, out_data}, exp_item);
                    end
                end
            end
            if (in_valid && in_ready) q.push_back({in_inv, ref4(in_data, in_inv)});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_inv !== 1'b0) begin errors++; $display("FAIL reset_out_inv got=%b exp=0", out_inv); end
        rst = 1'b0;
    endtask

    task automatic test_vectors;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inv    = 1'b0;
        in_data   = 128'hd42711aee0bf98f1b8b45de51e415230;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL enc_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 128'hd4bf5d30e0b452aeb84111f11e2798e5) begin errors++; $display("FAIL enc_vector got=%h exp=d4bf5d30e0b452aeb84111f11e2798e5", out_data); end
        checks++; if (out_inv !== 1'b0) begin errors++; $display("FAIL enc_inv got=%b exp=0", out_inv); end
        in_valid = 1'b1;
        in_inv   = 1'b1;
        in_data  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 'x;
        in_inv   = 1'bx;
        checks++; if (out_data !== 128'hd42711aee0bf98f1b8b45de51e415230) begin errors++; $display("FAIL dec_vector got=%h exp=d42711aee0bf98f1b8b45de51e415230", out_data); end
        checks++; if (out_inv !== 1'b1) begin errors++; $display("FAIL dec_inv got=%b exp=1", out_inv); end
        repeat (2) @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL x_ignored_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_nb8;
        logic [W8-1:0] orig, enc;
        for (int k = 0; k < 32; k++) orig[W8-1-8*k -: 8] = 8'(k);
        in_valid8 = 1'b1;
        in_inv8   = 1'b0;
        in_data8  = orig;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        enc = out_data8;
        checks++; if (out_valid8 !== 1'b1) begin errors++; $display("FAIL nb8_valid got=%b exp=1", out_valid8); end
        checks++; if (enc[W8-1-16 -: 8] !== 8'h0e) begin errors++; $display("FAIL nb8_row2_col0 got=%h exp=0e", enc[W8-1-16 -: 8]); end
        checks++; if (enc[W8-1-24 -: 8] !== 8'h13) begin errors++; $display("FAIL nb8_row3_col0 got=%h exp=13", enc[W8-1-24 -: 8]); end
        checks++; if (enc[W8-1-8 -: 8] !== 8'h05) begin errors++; $display("FAIL nb8_row1_col0 got=%h exp=05", enc[W8-1-8 -: 8]); end
        in_valid8 = 1'b1;
        in_inv8   = 1'b1;
        in_data8  = enc;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        checks++; if (out_data8 !== orig) begin errors++; $display("FAIL nb8_roundtrip got=%h exp=%h", out_data8, orig); end
        checks++; if (out_inv8 !== 1'b1) begin errors++; $display("FAIL nb8_inv got=%b exp=1", out_inv8); end
    endtask

    task automatic test_back_to_back;
        int n0;
        n0 = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_inv   = i[0];
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=1", i, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid cyc=%0d got=%b exp=1", i, out_valid); end
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        checks++; if (n_out - n0 !== 20) begin errors++; $display("FAIL b2b_count got=%0d exp=20", n_out - n0); end
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL b2b_leftover got=%0d exp=0", q.size()); end
    endtask

    task automatic test_backpressure;
        int n0;
        logic [W-1:0] a, held;
        n0 = n_out;
        a = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inv    = 1'b0;
        in_data   = a;
        @(posedge clk); #1;
        in_inv  = 1'b1;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        in_inv  = 1'b0;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        held = out_data;
        checks++; if (held !== ref4(a, 1'b0)) begin errors++; $display("FAIL bp_head got=%h exp=%h", held, ref4(a, 1'b0)); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
            checks++; if (out_data !== held || out_valid !== 1'b1) begin errors++; $display("FAIL bp_stable cyc=%0d got=%h exp=%h", i, out_data, held); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++; if (n_out - n0 !== 3) begin errors++; $display("FAIL bp_count got=%0d exp=3", n_out - n0); end
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL bp_leftover got=%0d exp=0", q.size()); end
    endtask

    task automatic test_reset_mid;
        int n0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inv    = 1'b0;
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rm_full got=%b exp=0", in_ready); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_async_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_async_ready got=%b exp=1", in_ready); end
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        n0 = n_out;
        in_valid = 1'b1;
        in_inv   = 1'b1;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++; if (n_out - n0 !== 1) begin errors++; $display("FAIL rm_only_output got=%0d exp=1", n_out - n0); end
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL rm_leftover got=%0d exp=0", q.size()); end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_inv     = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        in_valid8  = 1'b0;
        in_inv8    = 1'b0;
        in_data8   = '0;
        out_ready8 = 1'b1;
        test_reset();
        test_vectors();
        test_nb8();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rijndael_shift_rows.md
RIJNDAEL_SHIFT_ROWS -- requirements
Module: rijndael_shift_rows

Interface
- REQ-001: Parameter NB, default 4, Rijndael block width in 32-bit columns; legal values 4, 6, 8.
- REQ-002: Localparam W = 32*NB, data width in bits.
- REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-004: rst  input  1  asynchronous, active-high reset.
- REQ-005: in_valid  input  1  upstream offers a block.
- REQ-006: in_ready  output  1  block accepted when in_valid && in_ready at a rising edge; driven directly from a flop.
- REQ-007: in_data  input  W  state block, column-major.
- REQ-008: in_inv  input  1  0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt); sampled with in_data.
- REQ-009: out_valid  output  1  out_data/out_inv hold a result.
- REQ-010: out_ready  input  1  downstream takes result when out_valid && out_ready at a rising edge.
- REQ-011: out_data  output  W  transformed block.
- REQ-012: out_inv  output  1  in_inv value that accompanied this block.

Function
- REQ-013: Byte k = 4c + r (row r 0..3, column c 0..NB-1) SHALL occupy bits [W-1-8k : W-8-8k].
- REQ-014: Row shift offsets SHALL be C = {0,1,2,3} for NB=4 and NB=6, and {0,1,3,4} for NB=8.
- REQ-015: Encrypt: out(r,c) SHALL equal in(r,(c+C_r) mod NB).
- REQ-016: Decrypt: out(r,c) SHALL equal in(r,(c-C_r) mod NB); decrypt of encrypt SHALL be identity for every NB.
- REQ-017: The transform SHALL be pure byte routing, with no arithmetic; mode is selected per block, and mixed-mode streams need no bubbles.
- REQ-018: Latency SHALL be 1 cycle: a block accepted at edge N is presented with out_valid=1 after edge N.
- REQ-019: Storage SHALL be an output register (OR) plus a one-entry skid register (SK), each with a valid flag.
- REQ-020: States SHALL be EMPTY (OR and SK invalid), ONE (OR valid only) and FULL (both valid).
- REQ-021: in_ready SHALL equal !SK.valid.
- REQ-022: EMPTY + accept -> ONE, with the transformed input loaded into OR.
- REQ-023: ONE + accept + out_ready -> ONE, with OR replaced by the new result.
- REQ-024: ONE + accept + !out_ready -> FULL, with the new result loaded into SK.
- REQ-025: ONE + out_ready + no accept -> EMPTY.
- REQ-026: ONE + neither accept nor out_ready -> ONE, hold.
- REQ-027: FULL + out_ready -> ONE, with SK moved into OR.
- REQ-028: In FULL, no accept is possible because in_ready=0.
- REQ-029: FULL + !out_ready -> FULL, hold.
- REQ-030: While out_valid=1 and out_ready=0, out_data/out_inv SHALL stay stable; SK contents SHALL never be lost or reordered.
- REQ-031: Sustained in_valid=out_ready=1 SHALL give one block per cycle; ordering is strictly FIFO.
- REQ-032: in_data/in_inv SHALL be ignored when no accept occurs; X on them SHALL NOT propagate into state.
- REQ-033: Elaboration with NB not in {4,6,8} SHALL fail with an error.

Reset
- REQ-034: When rst=1, OR.valid and SK.valid SHALL clear immediately, asynchronously.
- REQ-035: Reset values: out_valid=0, out_data=0, out_inv=0, in_ready=1 (EMPTY).
- REQ-036: Reset mid-stream SHALL discard any blocks held in OR/SK.
- REQ-037: The first accept SHALL be the first rising edge at which rst is low and in_valid=1.

Verification
- REQ-038: NB=4, inv=0, in=d42711aee0bf98f1b8b45de51e415230 -> next cycle out=d4bf5d30e0b452aeb84111f11e2798e5, out_inv=0.
- REQ-039: NB=4, inv=1, in=d4bf5d30e0b452aeb84111f11e2798e5 -> out=d42711aee0bf98f1b8b45de51e415230, out_inv=1.
- REQ-040: NB=8, inv=0, in byte k = k (00..1f) -> row 2 byte at column 0 = 0e, row 3 byte at column 0 = 13; inv of result restores the input.
- REQ-041: 20 back-to-back blocks with alternating inv, out_ready held 1 -> one result per cycle, in order, in_ready stays 1.
- REQ-042: out_ready=0 for 3 cycles with in_valid=1 -> FULL reached, in_ready=0, out_data stable; out_ready=1 then drains both blocks in order with no loss or duplication.
- REQ-043: rst asserted in FULL between clock edges -> out_valid=0 and in_ready=1 immediately; the next accepted block is the only output.
